// File: rtl/cdc_rdptr_empty_level.sv
// Read-side pointer and status block for the dual-clock CDC FIFO.
// Keeps the binary and gray read pointers and derives empty, fill level, almost-empty and a sticky underflow flag.
module cdc_rdptr_empty_level #(
  parameter int ADDRSIZE  = 4,
  parameter int AE_THRESH = 2
) (
  input  logic                rd_clk,
  input  logic                rd_rst,
  input  logic [ADDRSIZE:0]   rdq2_wrptr,
  input  logic                rd_inc,
  input  logic                rd_clr_err,
  output logic                rd_empty,
  output logic                rd_almost_empty,
  output logic [ADDRSIZE:0]   rd_level,
  output logic                rd_underflow,
  output logic [ADDRSIZE-1:0] rd_addr,
  output logic [ADDRSIZE:0]   rd_ptr
);

  localparam logic [ADDRSIZE:0] AE_LVL = AE_THRESH[ADDRSIZE:0];

  logic [ADDRSIZE:0] rd_bin;
  logic [ADDRSIZE:0] bin_next;
  logic [ADDRSIZE:0] gray_next;
  logic [ADDRSIZE:0] wr_bin;
  logic [ADDRSIZE:0] level_next;
  logic              pop;
  logic              empty_next;
  logic              ae_next;

  assign pop = rd_inc & ~rd_empty;

  always_comb begin
    bin_next   = rd_bin + {{ADDRSIZE{1'b0}}, pop};
    gray_next  = (bin_next >> 1) ^ bin_next;
    // Each binary bit is the XOR of all gray bits at or above it.
    wr_bin     = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      wr_bin[i] = ^(rdq2_wrptr >> i);
    end
    level_next = wr_bin - bin_next;
    empty_next = (gray_next == rdq2_wrptr);
    ae_next    = (level_next <= AE_LVL);
  end

  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      rd_bin          <= '0;
      rd_ptr          <= '0;
      rd_empty        <= 1'b1;
      rd_almost_empty <= 1'b1;
      rd_level        <= '0;
    end else begin
      rd_bin          <= bin_next;
      rd_ptr          <= gray_next;
      rd_empty        <= empty_next;
      rd_almost_empty <= ae_next;
      rd_level        <= level_next;
    end
  end

  // Set has priority so a pop-while-empty is never lost to a concurrent clear.
  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      rd_underflow <= 1'b0;
    end else if (rd_inc && rd_empty) begin
      rd_underflow <= 1'b1;
    end else if (rd_clr_err) begin
      rd_underflow <= 1'b0;
    end
  end

  assign rd_addr = rd_bin[ADDRSIZE-1:0];

endmodule

// File: tb/tb_cdc_rdptr_empty_level.sv
// Directed bench for cdc_rdptr_empty_level with ADDRSIZE=4, AE_THRESH=2.
module tb_cdc_rdptr_empty_level;

  logic       rd_clk = 1'b0;
  logic       rd_rst = 1'b0;
  logic [4:0] rdq2_wrptr = '0;
  logic       rd_inc = 1'b0;
  logic       rd_clr_err = 1'b0;
  logic       rd_empty;
  logic       rd_almost_empty;
  logic [4:0] rd_level;
  logic       rd_underflow;
  logic [3:0] rd_addr;
  logic [4:0] rd_ptr;

  int n_cmp = 0;
  int n_err = 0;

  cdc_rdptr_empty_level #(.ADDRSIZE(4), .AE_THRESH(2)) dut (
    .rd_clk(rd_clk),
    .rd_rst(rd_rst),
    .rdq2_wrptr(rdq2_wrptr),
    .rd_inc(rd_inc),
    .rd_clr_err(rd_clr_err),
    .rd_empty(rd_empty),
    .rd_almost_empty(rd_almost_empty),
    .rd_level(rd_level),
    .rd_underflow(rd_underflow),
    .rd_addr(rd_addr),
    .rd_ptr(rd_ptr)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check_rst_state(input string tag);
    check({tag, "_empty"}, rd_empty, 1);
    check({tag, "_ae"}, rd_almost_empty, 1);
    check({tag, "_level"}, rd_level, 0);
    check({tag, "_ptr"}, rd_ptr, 0);
    check({tag, "_addr"}, rd_addr, 0);
    check({tag, "_uf"}, rd_underflow, 0);
  endtask

  logic [4:0] bin_m;
  logic [4:0] wr_m;

  initial begin
    tick();
    check_rst_state("rst0");
    tick();
    rd_rst = 1'b1;

    // Five entries written: gray 00111 = binary 5
    rdq2_wrptr = 5'b00111;
    tick();
    check("t2_empty", rd_empty, 0);
    check("t2_level", rd_level, 5);
    check("t2_ae", rd_almost_empty, 0);

    rd_inc = 1'b1;
    tick();
    check("t3_lvl1", rd_level, 4);
    check("t3_addr1", rd_addr, 1);
    check("t3_ptr1", rd_ptr, 5'b00001);
    check("t3_ae1", rd_almost_empty, 0);
    tick();
    check("t3_lvl2", rd_level, 3);
    check("t3_addr2", rd_addr, 2);
    check("t3_ptr2", rd_ptr, 5'b00011);
    check("t3_ae2", rd_almost_empty, 0);
    tick();
    check("t3_lvl3", rd_level, 2);
    check("t3_addr3", rd_addr, 3);
    check("t3_ptr3", rd_ptr, 5'b00010);
    check("t3_ae3", rd_almost_empty, 1);
    check("t3_uf", rd_underflow, 0);
    rd_inc = 1'b0;

    // Async reset mid-stream, observed before any clock edge
    rd_rst = 1'b0;
    #1;
    check_rst_state("rst1");
    rdq2_wrptr = 5'b00000;
    tick();
    rd_rst = 1'b1;

    // Underflow on empty FIFO
    rd_inc = 1'b1;
    tick();
    check("t4_uf_set", rd_underflow, 1);
    check("t4_ptr", rd_ptr, 0);
    check("t4_addr", rd_addr, 0);
    check("t4_empty", rd_empty, 1);
    rd_inc = 1'b0;
    tick();
    tick();
    check("t4_uf_hold", rd_underflow, 1);
    rd_inc = 1'b1;
    rd_clr_err = 1'b1;
    tick();
    check("t4_uf_setwins", rd_underflow, 1);
    check("t4_ptr2", rd_ptr, 0);
    rd_inc = 1'b0;
    tick();
    check("t4_uf_clr", rd_underflow, 0);
    rd_clr_err = 1'b0;

    // Streaming write+pop through the pointer wrap
    bin_m = 5'd0;
    wr_m = 5'd1;
    rdq2_wrptr = gray(wr_m);
    tick();
    check("t5_lvl0", rd_level, 1);
    check("t5_empty0", rd_empty, 0);
    rd_inc = 1'b1;
    for (int j = 1; j <= 32; j++) begin
      wr_m = wr_m + 5'd1;
      rdq2_wrptr = gray(wr_m);
      bin_m = bin_m + 5'd1;
      tick();
      check($sformatf("t5_lvl_%0d", j), rd_level, 1);
      check($sformatf("t5_empty_%0d", j), rd_empty, 0);
      check($sformatf("t5_addr_%0d", j), rd_addr, {1'b0, bin_m[3:0]});
      check($sformatf("t5_ptr_%0d", j), rd_ptr, gray(bin_m));
    end
    check("t5_uf", rd_underflow, 0);

    // Pop without write: drains to empty
    bin_m = bin_m + 5'd1;
    tick();
    check("t6_empty_a", rd_empty, 1);
    check("t6_lvl_a", rd_level, 0);
    check("t6_addr_a", rd_addr, {1'b0, bin_m[3:0]});
    rd_inc = 1'b0;

    // Level 1, then pop plus write in the same cycle, then pop alone
    wr_m = wr_m + 5'd1;
    rdq2_wrptr = gray(wr_m);
    tick();
    check("t6_lvl_b", rd_level, 1);
    rd_inc = 1'b1;
    wr_m = wr_m + 5'd1;
    rdq2_wrptr = gray(wr_m);
    bin_m = bin_m + 5'd1;
    tick();
    check("t6_empty_c", rd_empty, 0);
    check("t6_lvl_c", rd_level, 1);
    bin_m = bin_m + 5'd1;
    tick();
    check("t6_empty_d", rd_empty, 1);
    check("t6_lvl_d", rd_level, 0);
    check("t6_ptr_d", rd_ptr, gray(bin_m));
    check("t6_uf", rd_underflow, 0);
    rd_inc = 1'b0;

    // Full: writer 16 entries ahead, MSB differs
    rdq2_wrptr = gray(bin_m + 5'd16);
    tick();
    check("full_lvl", rd_level, 16);
    check("full_empty", rd_empty, 0);
    check("full_ae", rd_almost_empty, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
